mode_counter: RTL and testbench
===============================

# mode_counter

Parametrised multi-mode counter, successor to the 8-bit free-running counter used on the Tiny Tapeout `uo_out` pins. It adds the following:
- up/down direction
- a programmable modulus (limit)
- wrap or saturate behaviour at the boundary
- a synchronous parallel load
- an optional clock-enable prescaler
- a terminal-count pulse and a sticky overflow flag

It sits directly behind the pin wrapper. `count` drives `uo_out`, and control comes from `ui_in`/`uio_in`.

## Interface
- `WIDTH`, default 8: counter width in bits.
- `PRE_W`, default 8: prescaler divider width in bits.
- `clk` input 1: the single clock; all state changes on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: count enable; while low, counter and prescaler both hold.
- `load` input 1: synchronous load of `load_val`.
- `load_val` input WIDTH: value to load.
- `dir` input 1: 1 = count up, 0 = count down.
- `sat` input 1: 1 = saturate at the boundary, 0 = wrap.
- `limit` input WIDTH: modulus top value; the count range is 0..`limit`.
- `prescale` input PRE_W: a tick occurs every `prescale`+1 enabled cycles.
- `clr_ovf` input 1: clears `ovf`.
- `count` output WIDTH: current count (registered).
- `tc` output 1: one-cycle terminal-count pulse (registered).
- `ovf` output 1: sticky boundary-hit flag (registered).

## Operation
- Priority, highest first: `rst` > `load` > tick.
- Reset: `count`=0, `tc`=0, `ovf`=0, prescaler counter=0.
- Load: `count` takes `load_val` unclipped, even if above `limit`. The prescaler counter clears. `tc` is 0 that cycle and `ovf` is unchanged.
- Tick: `tick` = `en` && (prescaler counter == `prescale`). On a tick the prescaler counter returns to 0. Otherwise, when `en` is high, it increments.
- Up tick:
  - If `count` >= `limit` (boundary), the next count is 0 when `sat`=0, or `limit` when `sat`=1.
  - Otherwise the next count is `count`+1.
- Down tick:
  - If `count` == 0 (boundary), the next count is `limit` when `sat`=0, or 0 when `sat`=1.
  - Otherwise the next count is `count`-1, even if that is above `limit`.
- Boundary event (a tick at a boundary):
  - `tc`=1 for the next cycle only; this applies in saturate mode too, on every held tick.
  - `ovf` is set.
- `tc` is 0 on all other cycles.
- `ovf` clears on `clr_ovf`. If a set and a clear land in the same cycle, the set wins.
- Arithmetic is unsigned, modulo 2^WIDTH. `limit`=0 pins the count at 0 and produces `tc` on every tick.
- `dir`, `sat`, `limit` and `prescale` may change on any cycle. They take effect on the next tick, and no state is rebuilt.

## Timing
- All outputs are registered. Latency is 1 cycle from a sampled input to `count`/`tc`/`ovf`.
- `tc` rises in the same cycle that `count` shows its wrap or held value.
- Tick period is `prescale`+1 cycles of `en`=1. Deasserting `en` freezes the prescaler phase, and it resumes where it stopped.
- A `load` or `rst` in the middle of a prescale period restarts the phase. The first tick comes `prescale`+1 enabled cycles later.
- If `prescale` is reduced below the current prescaler counter value, the prescaler counter wraps through 2^PRE_W before the next tick. This is accepted behaviour.

## Configuration
- `MODE_COUNTER_PRESCALE_EN` defined:
  - The prescaler is instantiated.
  - `prescale` is honoured as above.
- `MODE_COUNTER_PRESCALE_EN` undefined:
  - No prescaler logic; `tick` = `en`.
  - The `prescale` port remains but is ignored, tied into an unused-signal reduction.
  - Behaviour is identical to the defined build with `prescale`=0.

## Structure
- Package `mode_counter_pkg`:
  - `DIR_UP`/`DIR_DOWN` and `MODE_WRAP`/`MODE_SAT` constants.
  - A default `WIDTH`/`PRE_W` localparam.
- Sub-module `mode_counter_prescaler`:
  - Inputs: `clk`, `rst`, `en`, `restart`, `prescale`.
  - Output: `tick`.
  - Instantiated only under the macro.
- The top holds the count, `tc` and `ovf` registers, plus the next-state logic.

## Test plan
- Reset: with `rst`=1 for 2 cycles → `count`=0, `tc`=0, `ovf`=0. After release with `en`=1, `dir`=1, `limit`=255, `prescale`=0 → `count`=1,2,3 on successive cycles.
- Up wrap: `limit`=5, `sat`=0, up, starting from 0 → `count` runs 0..5 then 0. `tc`=1 only in the cycle `count` returns to 0. `ovf`=1 thereafter.
- Down saturate: load 3, then `dir`=0, `sat`=1 → `count` goes 2,1,0,0,0. `tc` pulses once per held tick at 0.
- Load priority: `load`=1 with `load_val`=200 and `limit`=10 while `en`=1 → `count`=200. The next up tick gives 0 with `tc`=1.
- Prescaler (macro defined): `prescale`=3 → `count` increments every 4 cycles. With `en` dropped for 2 cycles mid-period, the increment is delayed by exactly 2 cycles.
- `ovf` clear: `clr_ovf` coinciding with a boundary event → `ovf` stays 1. `clr_ovf` alone → `ovf`=0 next cycle.

Source files
------------

// File: rtl/mode_counter_pkg.sv
// Shared constants for mode_counter: direction/boundary-mode encodings and default widths.
// The optional prescaler is selected with the MODE_COUNTER_PRESCALE_EN macro.
package mode_counter_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_PRE_W = 8;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

endpackage

// File: rtl/mode_counter_prescaler.sv
// Clock-enable prescaler: emits one tick every prescale+1 enabled cycles.
// Only instantiated when MODE_COUNTER_PRESCALE_EN is defined.
module mode_counter_prescaler
    import mode_counter_pkg::*;
#(
    parameter int unsigned PRE_W = DEF_PRE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             restart,
    input  logic [PRE_W-1:0] prescale,
    output logic             tick
);

    localparam logic [PRE_W-1:0] PHASE_ONE = PRE_W'(1);

    logic [PRE_W-1:0] phase;

    // Equality compare: if prescale drops below phase, phase wraps through 2^PRE_W.
    assign tick = en && (phase == prescale);

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            phase <= '0;
        end else if (en) begin
            phase <= tick ? '0 : phase + PHASE_ONE;
        end
    end

endmodule

// File: rtl/mode_counter.sv
// Multi-mode up/down counter with modulus, wrap/saturate, parallel load, tc pulse and sticky ovf.
// Define MODE_COUNTER_PRESCALE_EN to gate counting through mode_counter_prescaler.
module mode_counter
    import mode_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned PRE_W = DEF_PRE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic             sat,
    input  logic [WIDTH-1:0] limit,
    input  logic [PRE_W-1:0] prescale,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] COUNT_ONE = WIDTH'(1);

    logic             tick;
    logic             at_boundary;
    logic [WIDTH-1:0] count_next;

`ifdef MODE_COUNTER_PRESCALE_EN
    mode_counter_prescaler #(
        .PRE_W (PRE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .restart  (load),
        .prescale (prescale),
        .tick     (tick)
    );
`else
    logic unused_prescale;
    assign unused_prescale = ^prescale;
    assign tick            = en;
`endif

    // Up boundary uses >= so a loaded value above limit wraps/holds on the next up tick.
    always_comb begin
        at_boundary = 1'b0;
        count_next  = count;
        if (dir == DIR_UP) begin
            if (count >= limit) begin
                at_boundary = 1'b1;
                count_next  = (sat == MODE_SAT) ? limit : '0;
            end else begin
                count_next = count + COUNT_ONE;
            end
        end else begin
            if (count == '0) begin
                at_boundary = 1'b1;
                count_next  = (sat == MODE_SAT) ? '0 : limit;
            end else begin
                count_next = count - COUNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else if (load) begin
            count <= load_val;
            tc    <= 1'b0;
        end else begin
            tc <= tick && at_boundary;
            if (tick) begin
                count <= count_next;
            end
            if (tick && at_boundary) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mode_counter.sv
// Scoreboard bench for mode_counter: directed scenarios plus random stimulus against a behavioural model.
// Honours MODE_COUNTER_PRESCALE_EN the same way the design does.
module tb_mode_counter;
    import mode_counter_pkg::*;

    localparam int W = DEF_WIDTH;
    localparam int P = DEF_PRE_W;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         dir = 1'b1;
    logic         sat = 1'b0;
    logic [W-1:0] limit = '1;
    logic [P-1:0] prescale = '0;
    logic         clr_ovf = 1'b0;
    logic [W-1:0] count;
    logic         tc;
    logic         ovf;

    mode_counter #(
        .WIDTH (W),
        .PRE_W (P)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .dir      (dir),
        .sat      (sat),
        .limit    (limit),
        .prescale (prescale),
        .clr_ovf  (clr_ovf),
        .count    (count),
        .tc       (tc),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int c;
        bit t;
        bit o;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // stimulus staging variables, applied at the next falling edge
    bit s_rst, s_en, s_load, s_dir, s_sat, s_clr;
    int s_lv, s_lim, s_ps;

    // model state
    int m_cnt = 0;
    bit m_tc  = 0;
    bit m_ovf = 0;
    int m_ph  = 0;

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_step();
        bit tk;
        bit hit;
        if (s_rst) begin
            m_cnt = 0; m_tc = 0; m_ovf = 0; m_ph = 0;
        end else if (s_load) begin
            m_cnt = s_lv; m_tc = 0; m_ph = 0;
        end else begin
`ifdef MODE_COUNTER_PRESCALE_EN
            tk = s_en && (m_ph == s_ps);
`else
            tk = s_en;
`endif
            if (s_en) m_ph = tk ? 0 : (m_ph + 1) % (1 << P);
            hit = 0;
            if (tk) begin
                if (s_dir) begin
                    if (m_cnt >= s_lim) begin hit = 1; m_cnt = s_sat ? s_lim : 0; end
                    else m_cnt = m_cnt + 1;
                end else begin
                    if (m_cnt == 0) begin hit = 1; m_cnt = s_sat ? 0 : s_lim; end
                    else m_cnt = m_cnt - 1;
                end
            end
            m_tc = hit;
            if (hit) m_ovf = 1;
            else if (s_clr) m_ovf = 0;
        end
    endtask

    task automatic step();
        exp_t e;
        @(negedge clk);
        rst      = s_rst;
        en       = s_en;
        load     = s_load;
        load_val = W'(s_lv);
        dir      = s_dir;
        sat      = s_sat;
        limit    = W'(s_lim);
        prescale = P'(s_ps);
        clr_ovf  = s_clr;
        model_step();
        e.c = m_cnt; e.t = m_tc; e.o = m_ovf;
        exp_q.push_back(e);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // monitor: every cycle the DUT presents a new registered output
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("count", int'(count), e.c);
                check("tc", int'(tc), int'(e.t));
                check("ovf", int'(ovf), int'(e.o));
            end
        end
    end

    initial begin
        // reset then free-run up
        s_rst = 1; s_en = 0; s_load = 0; s_dir = 1; s_sat = 0; s_clr = 0;
        s_lv = 0; s_lim = 255; s_ps = 0;
        steps(2);
        s_rst = 0; s_en = 1;
        steps(3);
        // up wrap at limit 5
        s_rst = 1; step(); s_rst = 0;
        s_lim = 5;
        steps(8);
        // down saturate from 3
        s_load = 1; s_lv = 3; step(); s_load = 0;
        s_dir = 0; s_sat = 1;
        steps(6);
        // load above limit, then wrap
        s_dir = 1; s_sat = 0; s_lim = 10;
        s_load = 1; s_lv = 200; step(); s_load = 0;
        steps(2);
`ifdef MODE_COUNTER_PRESCALE_EN
        // prescale 3 with an enable gap mid-period
        s_rst = 1; step(); s_rst = 0;
        s_lim = 255; s_ps = 3;
        steps(9);
        s_en = 0; steps(2);
        s_en = 1; steps(7);
        s_ps = 0;
`endif
        // ovf clear racing a boundary event, then a plain clear
        s_lim = 2; s_dir = 1; s_sat = 0;
        s_load = 1; s_lv = 2; step(); s_load = 0;
        s_clr = 1; step();
        step();
        s_clr = 0; steps(2);
        // randomized
        for (int i = 0; i < 3000; i++) begin
            s_rst  = ($urandom_range(0, 99) == 0);
            s_load = ($urandom_range(0, 15) == 0);
            s_lv   = $urandom_range(0, (1 << W) - 1);
            s_en   = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 7) == 0) s_dir = $urandom_range(0, 1);
            if ($urandom_range(0, 7) == 0) s_sat = $urandom_range(0, 1);
            if ($urandom_range(0, 31) == 0)
                s_lim = ($urandom_range(0, 3) == 0) ? $urandom_range(0, (1 << W) - 1)
                                                    : $urandom_range(0, 6);
`ifdef MODE_COUNTER_PRESCALE_EN
            if ($urandom_range(0, 63) == 0) s_ps = $urandom_range(0, 3);
`else
            s_ps = $urandom_range(0, (1 << P) - 1);
`endif
            s_clr = !s_load && ($urandom_range(0, 7) == 0);
            step();
        end
        s_rst = 0; s_load = 0; s_en = 0; s_clr = 0;
        repeat (3) @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
